// File: rtl/nios_led_pwm_pkg.sv
// Shared constants for the LED PWM driver: register map, default widths and
// the counter-width helper used by the timebase.
package nios_led_pwm_pkg;

  localparam int DEF_NUM_LEDS       = 10;
  localparam int DEF_PWM_BITS       = 8;
  localparam int DEF_PRESCALE       = 196;
  localparam int DEF_BLINK_DIV_BITS = 16;
  localparam int DEF_BLINK_DIV_RST  = 499;

  localparam logic [DEF_PWM_BITS-1:0] DUTY_ALL_ONES = '1;

  localparam logic [1:0] ADDR_DUTY       = 2'd0;
  localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
  localparam logic [1:0] ADDR_BLINK_DIV  = 2'd2;
  localparam logic [1:0] ADDR_STATUS     = 2'd3;

  // A count of 1 still needs a one-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nios_led_pwm_timebase.sv
// PWM timebase: prescaler, PWM frame counter and the blink frame divider that
// produces blink_phase.
module nios_led_pwm_timebase
  import nios_led_pwm_pkg::*;
#(
  parameter int PWM_BITS       = DEF_PWM_BITS,
  parameter int PRESCALE       = DEF_PRESCALE,
  parameter int BLINK_DIV_BITS = DEF_BLINK_DIV_BITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BLINK_DIV_BITS-1:0] blink_div_i,
  input  logic                      blink_div_wr_i,
  output logic [PWM_BITS-1:0]       pwm_cnt_o,
  output logic                      frame_end_o,
  output logic                      blink_phase_o
);

  localparam int                PRE_W   = cnt_width(PRESCALE);
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]          pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_DIV_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                      blink_phase_q, blink_phase_d;
  logic                      tick;
  logic                      frame_end;

  assign tick      = (pre_cnt_q == PRE_MAX);
  assign frame_end = tick & (&pwm_cnt_q);

  always_comb begin
    pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    // Reprogramming the divider restarts the blink period in the lit phase,
    // even if a frame ends on the same clock.
    if (blink_div_wr_i) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (frame_end) begin
      if (frame_cnt_q == blink_div_i) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign pwm_cnt_o     = pwm_cnt_q;
  assign frame_end_o   = frame_end;
  assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/nios_led_pwm_driver.sv
// LED PWM/blink stage between the LED PIO out_port and the board pins.
// Define LED_PWM_FADE_EN to ramp duty_active one step per frame toward DUTY.
module nios_led_pwm_driver
  import nios_led_pwm_pkg::*;
#(
  parameter int NUM_LEDS       = DEF_NUM_LEDS,
  parameter int PWM_BITS       = DEF_PWM_BITS,
  parameter int PRESCALE       = DEF_PRESCALE,
  parameter int BLINK_DIV_BITS = DEF_BLINK_DIV_BITS,
  parameter int BLINK_DIV_RST  = DEF_BLINK_DIV_RST
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam logic [PWM_BITS-1:0] DUTY_ONES = '1;

  logic [PWM_BITS-1:0]       duty_q, duty_d;
  logic [NUM_LEDS-1:0]       blink_mask_q, blink_mask_d;
  logic [BLINK_DIV_BITS-1:0] blink_div_q, blink_div_d;
  logic [PWM_BITS-1:0]       duty_active_q, duty_active_d;
  logic [NUM_LEDS-1:0]       led_out_q, led_out_d;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic                      frame_end;
  logic                      blink_phase;
  logic                      bus_wr;
  logic                      blink_div_wr;
  logic                      pwm_on;
  logic                      unused_wdata;

  // Bus: a write lands on the clock edge where chipselect is high and write_n
  // is low; reads are a zero-wait-state combinational mux on address.
  assign bus_wr       = chipselect & ~write_n;
  assign blink_div_wr = bus_wr & (address == ADDR_BLINK_DIV);
  assign unused_wdata = ^writedata;

  nios_led_pwm_timebase #(
    .PWM_BITS       (PWM_BITS),
    .PRESCALE       (PRESCALE),
    .BLINK_DIV_BITS (BLINK_DIV_BITS)
  ) u_timebase (
    .clk            (clk),
    .reset_n        (reset_n),
    .blink_div_i    (blink_div_q),
    .blink_div_wr_i (blink_div_wr),
    .pwm_cnt_o      (pwm_cnt),
    .frame_end_o    (frame_end),
    .blink_phase_o  (blink_phase)
  );

  always_comb begin
    duty_d       = duty_q;
    blink_mask_d = blink_mask_q;
    blink_div_d  = blink_div_q;
    if (bus_wr) begin
      case (address)
        ADDR_DUTY:       duty_d       = writedata[PWM_BITS-1:0];
        ADDR_BLINK_MASK: blink_mask_d = writedata[NUM_LEDS-1:0];
        ADDR_BLINK_DIV:  blink_div_d  = writedata[BLINK_DIV_BITS-1:0];
        default:         ;
      endcase
    end
  end

  // duty_active only moves at a frame boundary so a frame is never split.
  always_comb begin
    duty_active_d = duty_active_q;
    if (frame_end) begin
`ifdef LED_PWM_FADE_EN
      if (duty_active_q < duty_q) begin
        duty_active_d = duty_active_q + 1'b1;
      end else if (duty_active_q > duty_q) begin
        duty_active_d = duty_active_q - 1'b1;
      end
`else
      duty_active_d = duty_q;
`endif
    end
  end

  assign pwm_on    = (duty_active_q == DUTY_ONES) | (pwm_cnt < duty_active_q);
  assign led_out_d = led_in & {NUM_LEDS{pwm_on}} & (~blink_mask_q | {NUM_LEDS{blink_phase}});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty_q        <= DUTY_ONES;
      blink_mask_q  <= '0;
      blink_div_q   <= BLINK_DIV_BITS'(BLINK_DIV_RST);
      duty_active_q <= DUTY_ONES;
      led_out_q     <= '0;
    end else begin
      duty_q        <= duty_d;
      blink_mask_q  <= blink_mask_d;
      blink_div_q   <= blink_div_d;
      duty_active_q <= duty_active_d;
      led_out_q     <= led_out_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DUTY:       readdata[PWM_BITS-1:0]       = duty_q;
      ADDR_BLINK_MASK: readdata[NUM_LEDS-1:0]       = blink_mask_q;
      ADDR_BLINK_DIV:  readdata[BLINK_DIV_BITS-1:0] = blink_div_q;
      default:         readdata[PWM_BITS:0]         = {blink_phase, duty_active_q};
    endcase
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_nios_led_pwm_driver.sv
// Bench for nios_led_pwm_driver (PRESCALE=1): directed scenario checks plus a
// frame-arithmetic reference model compared against led_out every cycle.
`timescale 1ns/1ps
module tb_nios_led_pwm_driver;
  import nios_led_pwm_pkg::*;

  localparam int NL  = 10;
  localparam int PB  = 8;
  localparam int PS  = 1;
  localparam int BDB = 16;
  localparam int BDR = 499;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [NL-1:0] led_in = '0;
  logic [NL-1:0] led_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  nios_led_pwm_driver #(
    .NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(PS),
    .BLINK_DIV_BITS(BDB), .BLINK_DIV_RST(BDR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .led_in(led_in), .led_out(led_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Frame position comes from clocks since reset; blink phase from the number
  // of frame ends since reset or the last BLINK_DIV write.
  int unsigned   m_t;
  int unsigned   m_frames;
  int unsigned   m_div;
  int unsigned   m_pos;
  logic [PB-1:0] m_duty;
  logic [PB-1:0] m_active;
  logic [NL-1:0] m_mask;
  logic          m_on;
  logic          m_phase;
  logic [NL-1:0] exp_led;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_t = 0; m_frames = 0; m_div = BDR;
      m_duty = '1; m_active = '1; m_mask = '0; exp_led = '0;
    end else begin
      m_pos   = m_t % 256;
      m_phase = (((m_frames / (m_div + 1)) % 2) == 0);
      m_on    = (m_active == 8'hFF) || (m_pos < int'(m_active));
      exp_led = led_in & {NL{m_on}} & (~m_mask | {NL{m_phase}});
      if (m_pos == 255) begin
        m_frames++;
`ifdef LED_PWM_FADE_EN
        if (m_active < m_duty) m_active = m_active + 8'd1;
        else if (m_active > m_duty) m_active = m_active - 8'd1;
`else
        m_active = m_duty;
`endif
      end
      m_t++;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_duty = writedata[PB-1:0];
          2'd1: m_mask = writedata[NL-1:0];
          2'd2: begin m_div = writedata[BDB-1:0]; m_frames = 0; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0; led_in = '1;
    repeat (2) @(negedge clk);
    n_cmp++; if (led_out !== '0) begin n_fail++; $display("FAIL reset_led: got %h expected 000", led_out); end
    reset_n = 1'b1;
    exp_q = {32'h0000_00FF, 32'h0, 32'(BDR), 32'h0000_01FF};
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_cmp++; if (rd !== exp_q[0]) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected %h", a, rd, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_cmp++; if (led_out !== 10'h3FF) begin n_fail++; $display("FAIL reset_on cyc%0d: got %h expected 3ff", i, led_out); end
      end
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
    end
    bus_write(ADDR_STATUS, 32'h0);
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h1FF) begin n_fail++; $display("FAIL status_ro: got %h expected 000001ff", rd); end
  endtask

`ifndef LED_PWM_FADE_EN
  task automatic test_duty_mid_frame();
    logic [31:0] rd;
    int waited, highs;
    led_in = 10'($urandom_range(1, 1023));
    repeat ($urandom_range(20, 150)) begin
      @(negedge clk);
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
    end
    bus_write(ADDR_DUTY, 32'd64);
    bus_read(ADDR_DUTY, rd);
    n_cmp++; if (rd !== 32'd64) begin n_fail++; $display("FAIL duty_rd: got %h expected 40", rd); end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd[7:0] !== 8'hFF) begin n_fail++; $display("FAIL duty_hold: got %h expected ff", rd[7:0]); end
    waited = 0;
    while (rd[7:0] !== 8'd64 && waited < 600) begin
      @(negedge clk); waited++;
      n_cmp++; if (led_out !== led_in) begin n_fail++; $display("FAIL cur_frame: got %h expected %h", led_out, led_in); end
      bus_read(ADDR_STATUS, rd);
    end
    n_cmp++; if (rd[7:0] !== 8'd64) begin n_fail++; $display("FAIL duty_load: got %h expected 40", rd[7:0]); end
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (led_out === led_in) highs++;
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
    end
    n_cmp++; if (highs != 128) begin n_fail++; $display("FAIL duty64_highs: got %0d expected 128", highs); end
  endtask

  task automatic test_duty_extremes();
    logic [31:0]   rd;
    logic [NL-1:0] prev;
    int waited;
    bus_write(ADDR_DUTY, 32'd0);
    waited = 0; bus_read(ADDR_STATUS, rd);
    while (rd[7:0] !== 8'd0 && waited < 600) begin
      @(negedge clk); waited++;
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
      bus_read(ADDR_STATUS, rd);
    end
    n_cmp++; if (rd[7:0] !== 8'd0) begin n_fail++; $display("FAIL duty0_load: got %h expected 00", rd[7:0]); end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_cmp++; if (led_out !== '0) begin n_fail++; $display("FAIL duty0_off: got %h expected 000", led_out); end
    end
    bus_write(ADDR_DUTY, 32'd255);
    waited = 0; bus_read(ADDR_STATUS, rd);
    while (rd[7:0] !== 8'hFF && waited < 600) begin
      @(negedge clk); waited++;
      n_cmp++; if (led_out !== '0) begin n_fail++; $display("FAIL duty0_tail: got %h expected 000", led_out); end
      bus_read(ADDR_STATUS, rd);
    end
    n_cmp++; if (rd[7:0] !== 8'hFF) begin n_fail++; $display("FAIL duty255_load: got %h expected ff", rd[7:0]); end
    prev = led_in;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_cmp++; if (led_out !== prev) begin n_fail++; $display("FAIL duty255_on: got %h expected %h", led_out, prev); end
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
      led_in = 10'($urandom); prev = led_in;
    end
  endtask

  task automatic test_blink();
    logic [31:0] rd;
    logic        prev;
    int          toggles[$];
    int          waited;
    bus_write(ADDR_BLINK_MASK, 32'h001);
    led_in = 10'h003;
    bus_write(ADDR_BLINK_DIV, 32'd1);
    prev = led_out[0];
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      n_cmp++; if (led_out[1] !== 1'b1) begin n_fail++; $display("FAIL blink_bit1: got %b expected 1", led_out[1]); end
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
      if (led_out[0] !== prev) begin toggles.push_back(i); prev = led_out[0]; end
    end
    n_cmp++; if (toggles.size() < 3) begin n_fail++; $display("FAIL blink_count: got %0d expected >=3", toggles.size()); end
    for (int k = 1; k < toggles.size(); k++) begin
      n_cmp++; if (toggles[k] - toggles[k-1] != 512) begin n_fail++; $display("FAIL blink_period: got %0d expected 512", toggles[k] - toggles[k-1]); end
    end
    // Find the clock where blink_phase rises; the next toggle is 512 clocks on.
    waited = 0; bus_read(ADDR_STATUS, rd); prev = rd[8];
    while (!(prev === 1'b0 && rd[8] === 1'b1) && waited < 1200) begin
      @(negedge clk); waited++;
      prev = rd[8];
      bus_read(ADDR_STATUS, rd);
    end
    n_cmp++; if (rd[8] !== 1'b1) begin n_fail++; $display("FAIL blink_rise: got %b expected 1", rd[8]); end
    repeat (511) begin
      @(negedge clk);
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
    end
    bus_write(ADDR_BLINK_DIV, 32'd1);
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd[8] !== 1'b1) begin n_fail++; $display("FAIL blink_wr_prio: got %b expected 1", rd[8]); end
    repeat (511) begin
      @(negedge clk);
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
    end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd[8] !== 1'b1) begin n_fail++; $display("FAIL blink_restart_hold: got %b expected 1", rd[8]); end
    @(negedge clk);
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd[8] !== 1'b0) begin n_fail++; $display("FAIL blink_restart_toggle: got %b expected 0", rd[8]); end
  endtask
`endif

`ifdef LED_PWM_FADE_EN
  task automatic test_fade();
    logic [31:0] rd;
    logic [7:0]  last;
    bus_write(ADDR_DUTY, 32'd250);
    exp_q = {32'd254, 32'd253, 32'd252, 32'd251, 32'd250};
    bus_read(ADDR_STATUS, rd); last = rd[7:0];
    for (int i = 0; i < 256 * 8; i++) begin
      @(negedge clk);
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
      bus_read(ADDR_STATUS, rd);
      if (rd[7:0] !== last) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL fade_extra: got %h expected no change", rd[7:0]); end
        else begin
          if (rd[7:0] !== exp_q[0][7:0]) begin n_fail++; $display("FAIL fade_step: got %h expected %h", rd[7:0], exp_q[0][7:0]); end
          void'(exp_q.pop_front());
        end
        last = rd[7:0];
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fade_missing: got %0d steps left expected 0", exp_q.size()); end
    n_cmp++; if (rd[7:0] !== 8'd250) begin n_fail++; $display("FAIL fade_final: got %h expected fa", rd[7:0]); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n, highs, exp_first;
`ifdef LED_PWM_FADE_EN
    exp_first = 254;
`else
    exp_first = 10;
`endif
    bus_write(ADDR_BLINK_MASK, 32'h0);
    bus_write(ADDR_DUTY, 32'd10);
    led_in = 10'($urandom_range(1, 1023));
    repeat ($urandom_range(30, 200)) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++; if (led_out !== '0) begin n_fail++; $display("FAIL rstmid_led: got %h expected 000", led_out); end
    bus_read(ADDR_DUTY, rd);
    n_cmp++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL rstmid_duty: got %h expected ff", rd); end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h1FF) begin n_fail++; $display("FAIL rstmid_status: got %h expected 1ff", rd); end
    bus_write(ADDR_DUTY, 32'd10);
    n = 1; bus_read(ADDR_STATUS, rd);
    while (rd[7:0] === 8'hFF && n < 600) begin
      @(negedge clk); n++;
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
      bus_read(ADDR_STATUS, rd);
    end
    n_cmp++; if (n != 256) begin n_fail++; $display("FAIL rstmid_frame_len: got %0d expected 256", n); end
    n_cmp++; if (rd[7:0] !== 8'(exp_first)) begin n_fail++; $display("FAIL rstmid_load: got %h expected %h", rd[7:0], 8'(exp_first)); end
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_out === led_in) highs++;
      n_cmp++; if (led_out !== exp_led) begin n_fail++; $display("FAIL model: got %h expected %h", led_out, exp_led); end
    end
    n_cmp++; if (highs != exp_first) begin n_fail++; $display("FAIL rstmid_highs: got %0d expected %0d", highs, exp_first); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (3) @(negedge clk);
    test_reset();
`ifdef LED_PWM_FADE_EN
    test_fade();
`else
    test_duty_mid_frame();
    test_duty_extremes();
    test_blink();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
